// File: rtl/id_stage.sv
// id_stage: instruction-decode stage in front of the register file.
//
// Takes 16-bit instructions from fetch over a valid/ready handshake, decodes
// them, drives the register-file read addresses combinationally and loads
// the ID/EX pipeline register. Inserts a single bubble on a load-use hazard,
// honours downstream backpressure (ex_ready) and flush.
//
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-high reset
//   if_valid/if_instr       instruction from fetch
//   if_ready                stage accepts if_instr this cycle
//   flush                   kills held and incoming instruction
//   ex_ready                execute stage accepts ID/EX contents
//   RAddr1/RAddr2           register file read addresses (combinational)
//   ex_valid .. ex_illegal  ID/EX pipeline register
//   stall_cnt               hazard-bubble counter (only with ID_STALL_CNT_EN)
//
// Optional feature: define ID_STALL_CNT_EN to add the saturating stall_cnt
// output.
module id_stage #(
  parameter int DSIZE = 16,
  parameter int RSIZE = 4,
  parameter int ISIZE = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             if_valid,
  input  logic [ISIZE-1:0] if_instr,
  output logic             if_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic [RSIZE-1:0] RAddr1,
  output logic [RSIZE-1:0] RAddr2,
  output logic             ex_valid,
  output logic [3:0]       ex_op,
  output logic [RSIZE-1:0] ex_waddr,
  output logic             ex_wen,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic [DSIZE-1:0] ex_imm,
  output logic             ex_illegal
`ifdef ID_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    logic [RSIZE-1:0] waddr;
    logic             wen;
    logic             mem_rd;
    logic             mem_wr;
    logic [DSIZE-1:0] imm;
    logic             illegal;
  } dec_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  function automatic dec_t decode(input logic [ISIZE-1:0] ins);
    dec_t       d;
    logic [3:0] op;
    logic       writes;
    d      = '0;
    op     = ins[15:12];
    writes = 1'b0;
    if (op >= 4'd13) begin
      d.illegal = 1'b1;
    end else begin
      d.valid  = 1'b1;
      d.op     = op;
      d.mem_rd = (op == 4'd8);
      d.mem_wr = (op == 4'd9);
      writes   = (op <= 4'd8) || (op == 4'd10);
      case (op)
        4'd8, 4'd9, 4'd11: d.imm = DSIZE'(ins[3:0]);
        4'd10:             d.imm = DSIZE'(ins[7:0]);
        4'd12:             d.imm = DSIZE'(ins[11:0]);
        default:           d.imm = '0;
      endcase
      // A write to R0 is no write at all: both waddr and wen collapse to 0.
      if (writes && (ins[11:8] != 4'd0)) begin
        d.wen   = 1'b1;
        d.waddr = RSIZE'(ins[11:8]);
      end
    end
    return d;
  endfunction

  // Read-port addresses; unused ports read R0.
  function automatic logic [2*RSIZE-1:0] src_addrs(input logic [ISIZE-1:0] ins);
    logic [RSIZE-1:0] rd, rs1, rs2;
    rd  = RSIZE'(ins[11:8]);
    rs1 = RSIZE'(ins[7:4]);
    rs2 = RSIZE'(ins[3:0]);
    case (ins[15:12])
      4'd0, 4'd1, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd7: return {rs1, rs2};
      4'd8:                   return {rs1, {RSIZE{1'b0}}};
      4'd9:                   return {rs1, rd};
      4'd11:                  return {rd, rs1};
      default:                return '0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic             held_valid;
  logic [ISIZE-1:0] held_instr;
  logic [ISIZE-1:0] cur_instr;
  logic             cur_valid;
  logic             hazard;
  dec_t             dec;
  dec_t             ex_q;
  state_t           state_q, state_d;

  // Decode point: the held instruction has priority over fetch.
  assign if_ready  = !held_valid;
  assign cur_instr = held_valid ? held_instr : if_instr;
  assign cur_valid = held_valid || if_valid;
  assign dec       = decode(cur_instr);
  assign {RAddr1, RAddr2} = cur_valid ? src_addrs(cur_instr) : '0;

  // Sources are 0 for unused ports and ex_waddr is nonzero, so comparing the
  // driven read addresses covers exactly the used sources.
  assign hazard = cur_valid && (state_q == RUN) && ex_q.valid && ex_q.mem_rd &&
                  (ex_q.waddr != '0) &&
                  ((RAddr1 == ex_q.waddr) || (RAddr2 == ex_q.waddr));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hazard && ex_ready) state_d = STALL;
      STALL:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (flush) state_d = RUN;
  end

  // ID/EX boundary: control and pipeline register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= RUN;
      held_valid <= 1'b0;
      ex_q       <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        held_valid <= 1'b0;
        ex_q       <= '0;
      end else if (ex_ready) begin
        if (hazard) begin
          ex_q       <= '0;
          held_valid <= 1'b1;
        end else begin
          ex_q       <= cur_valid ? dec : '0;
          held_valid <= 1'b0;
        end
      end else if (if_valid && !held_valid) begin
        held_valid <= 1'b1;
      end
    end
  end

  // Skid-buffer payload: tracks fetch whenever the buffer is empty, so it
  // already holds the right word on the cycle held_valid rises.
  always_ff @(posedge Clock) begin
    if (!held_valid) held_instr <= if_instr;
  end

  assign ex_valid   = ex_q.valid;
  assign ex_op      = ex_q.op;
  assign ex_waddr   = ex_q.waddr;
  assign ex_wen     = ex_q.wen;
  assign ex_mem_rd  = ex_q.mem_rd;
  assign ex_mem_wr  = ex_q.mem_wr;
  assign ex_imm     = ex_q.imm;
  assign ex_illegal = ex_q.illegal;

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_cnt <= 16'd0;
    end else if (!flush && ex_ready && hazard) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        Clock = 1'b0;
  logic        Reset, if_valid, flush, ex_ready;
  logic [15:0] if_instr;
  logic        if_ready;
  logic [3:0]  RAddr1, RAddr2;
  logic        ex_valid, ex_wen, ex_mem_rd, ex_mem_wr, ex_illegal;
  logic [3:0]  ex_op, ex_waddr;
  logic [15:0] ex_imm;
`ifdef ID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  id_stage dut (
    .Clock(Clock), .Reset(Reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .ex_ready(ex_ready),
    .RAddr1(RAddr1), .RAddr2(RAddr2), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_waddr(ex_waddr), .ex_wen(ex_wen), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_imm(ex_imm), .ex_illegal(ex_illegal)
`ifdef ID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 Clock = ~Clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what execute should see, from the instruction set rules.
  typedef struct {
    bit       valid;
    int       op;
    int       waddr;
    bit       wen, mrd, mwr, ill;
    int       imm;
  } ex_t;

  function automatic ex_t ref_dec(input logic [15:0] i);
    ex_t e;
    int op = int'(i[15:12]);
    int rd = int'(i[11:8]);
    e = '{default: 0};
    if (op >= 13) begin
      e.ill = 1;
      return e;
    end
    e.valid = 1;
    e.op    = op;
    e.mrd   = (op == 8);
    e.mwr   = (op == 9);
    if ((op <= 8 || op == 10) && rd != 0) begin
      e.wen   = 1;
      e.waddr = rd;
    end
    if (op == 8 || op == 9 || op == 11) e.imm = int'(i[3:0]);
    else if (op == 10) e.imm = int'(i[7:0]);
    else if (op == 12) e.imm = int'(i[11:0]);
    return e;
  endfunction

  // Registers an instruction reads, in port order.
  function automatic void ref_src(input logic [15:0] i, output int a1, output int a2);
    int op = int'(i[15:12]);
    a1 = 0; a2 = 0;
    if (op <= 7)       begin a1 = int'(i[7:4]);  a2 = int'(i[3:0]); end
    else if (op == 8)  begin a1 = int'(i[7:4]); end
    else if (op == 9)  begin a1 = int'(i[7:4]);  a2 = int'(i[11:8]); end
    else if (op == 11) begin a1 = int'(i[11:8]); a2 = int'(i[7:4]); end
  endfunction

  logic [15:0] pend[$];     // instructions accepted but not yet issued (0 or 1)
  ex_t         m_ex;
  int          m_cnt;
  logic        obs_ready;
  logic [3:0]  obs_ra1, obs_ra2;

  task automatic model_reset();
    pend.delete();
    m_ex  = '{default: 0};
    m_cnt = 0;
  endtask

  task automatic step(input logic rst, input logic iv, input logic [15:0] ins,
                      input logic fl, input logic er);
    logic [15:0] cur;
    bit          cur_v, haz;
    int          a1, a2;
    Reset = rst; if_valid = iv; if_instr = ins; flush = fl; ex_ready = er;
    #3;
    obs_ready = if_ready; obs_ra1 = RAddr1; obs_ra2 = RAddr2;
    cur_v = (pend.size() != 0) || iv;
    cur   = (pend.size() != 0) ? pend[0] : ins;
    if (cur_v) ref_src(cur, a1, a2);
    else begin a1 = 0; a2 = 0; end
    check("if_ready", if_ready, (pend.size() == 0));
    check("raddr1", RAddr1, a1);
    check("raddr2", RAddr2, a2);
    haz = cur_v && m_ex.valid && m_ex.mrd && m_ex.waddr != 0 &&
          (a1 == m_ex.waddr || a2 == m_ex.waddr);
    if (rst) model_reset();
    else if (fl) begin
      pend.delete();
      m_ex = '{default: 0};
    end else if (er && haz) begin
      if (pend.size() == 0) pend.push_back(ins);
      m_ex = '{default: 0};
      if (m_cnt < 65535) m_cnt++;
    end else if (er) begin
      m_ex = cur_v ? ref_dec(cur) : '{default: 0};
      pend.delete();
    end else if (iv && pend.size() == 0) begin
      pend.push_back(ins);
    end
    @(posedge Clock); #1;
    check("ex_valid", ex_valid, m_ex.valid);
    check("ex_op", ex_op, m_ex.op);
    check("ex_waddr", ex_waddr, m_ex.waddr);
    check("ex_wen", ex_wen, m_ex.wen);
    check("ex_mem_rd", ex_mem_rd, m_ex.mrd);
    check("ex_mem_wr", ex_mem_wr, m_ex.mwr);
    check("ex_imm", ex_imm, m_ex.imm);
    check("ex_illegal", ex_illegal, m_ex.ill);
`ifdef ID_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  task automatic idle(input logic er);
    step(1'b0, 1'b0, 16'h0000, 1'b0, er);
  endtask

  initial begin
    logic [15:0] ins;
    logic [3:0]  op;
    Reset = 1'b1; if_valid = 1'b0; if_instr = '0; flush = 1'b0; ex_ready = 1'b1;
    model_reset();
    @(posedge Clock); #1;
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("rst_ex_valid", ex_valid, 0);
    idle(1'b1);
    check("rst_if_ready", obs_ready, 1);

    // ADD R3,R1,R2
    step(1'b0, 1'b1, 16'h0312, 1'b0, 1'b1);
    check("add_ra1", obs_ra1, 1);
    check("add_ra2", obs_ra2, 2);
    check("add_waddr", ex_waddr, 3);
    check("add_wen", ex_wen, 1);

    // LW R4,[R1+2] then ADD R5,R4,R6: one bubble
    step(1'b0, 1'b1, 16'h8412, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0546, 1'b0, 1'b1);
    check("lu_bubble", ex_valid, 0);
    idle(1'b1);
    check("lu_stall_rdy", obs_ready, 0);
    check("lu_issue", ex_waddr, 5);

    // LW R0 then ADD R5,R0,R6: no hazard
    step(1'b0, 1'b1, 16'h8012, 1'b0, 1'b1);
    check("lw0_wen", ex_wen, 0);
    step(1'b0, 1'b1, 16'h0506, 1'b0, 1'b1);
    check("lw0_nobubble", ex_valid, 1);

    // SW held under 3 cycles of backpressure
    step(1'b0, 1'b1, 16'h9712, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      check("sw_ra1", obs_ra1, 1);
      check("sw_ra2", obs_ra2, 7);
      check("sw_ready", obs_ready, 0);
    end
    idle(1'b1);
    check("sw_issue", ex_mem_wr, 1);

    // Hazard and flush together
    step(1'b0, 1'b1, 16'h8412, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0546, 1'b1, 1'b1);
    check("fl_valid", ex_valid, 0);
    idle(1'b1);
    check("fl_ready", obs_ready, 1);

    // Illegal op
    step(1'b0, 1'b1, 16'hE000, 1'b0, 1'b1);
    check("ill_pulse", ex_illegal, 1);
    idle(1'b1);
    check("ill_clear", ex_illegal, 0);

    // Reset during STALL
    step(1'b0, 1'b1, 16'h8412, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0546, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("rst_stall_op", ex_op, 0);
    idle(1'b1);
    check("rst_stall_rdy", obs_ready, 1);

    // Randomized traffic on a small register pool to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      op  = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      ins = {op, 2'b00, 2'($urandom), 2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      if ($urandom_range(0, 7) == 0) ins[11:0] = 12'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), ins,
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage sitting directly upstream of the register file.
- Accepts 16-bit instructions from fetch through a valid/ready handshake and decodes them.
- Drives RAddr1/RAddr2 combinationally into the register file, whose registered RData appears alongside this block's ID/EX pipeline register.
- Detects load-use hazards and inserts one bubble; supports flush and downstream backpressure.

Parameters:
DSIZE, 16, data width; ex_imm width
RSIZE, 4, register address width (16 registers, R0 reads as zero)
ISIZE, 16, instruction width

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
if_valid  input  1  fetch presents an instruction
if_instr  input  ISIZE  instruction: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4
if_ready  output  1  stage accepts if_instr this cycle
flush  input  1  kill held and incoming instruction (branch taken)
ex_ready  input  1  execute stage can accept ID/EX contents
RAddr1  output  RSIZE  register file read address 1 (combinational)
RAddr2  output  RSIZE  register file read address 2 (combinational)
ex_valid  output  1  ID/EX holds a real instruction
ex_op  output  4  registered opcode
ex_waddr  output  RSIZE  registered destination; 0 when no write
ex_wen  output  1  registered write enable
ex_mem_rd  output  1  registered load flag
ex_mem_wr  output  1  registered store flag
ex_imm  output  DSIZE  registered immediate, zero-extended
ex_illegal  output  1  registered pulse; op 13–15 decoded

Behaviour:
- Decode:
  - op 0–7: ALU reg-reg. RAddr1=rs1, RAddr2=rs2, wen=1, waddr=rd.
  - op 8 LW: RAddr1=rs1, RAddr2=0, imm=imm4, mem_rd=1, wen=1.
  - op 9 SW: RAddr1=rs1, RAddr2=rd, imm=imm4, mem_wr=1, wen=0.
  - op 10 LLI: no reads, imm={rs1,rs2} (8 bits), wen=1.
  - op 11 BEQ: RAddr1=rd, RAddr2=rs1, imm=imm4, wen=0.
  - op 12 JMP: no reads, imm=if_instr[11:0], wen=0.
  - op 13–15: issue as bubble (ex_valid=0), ex_illegal=1 for one cycle.
- Unused read ports drive address 0. ex_wen is forced 0 whenever waddr=0.
- Holding register: one-entry skid buffer. if_ready = !held_valid.
  - An accepted instruction that cannot advance (ex_ready=0 or hazard) is captured.
  - RAddr1/RAddr2 decode from the held instruction when held_valid=1, otherwise from if_instr.
- ID/EX advance:
  - Advances when ex_ready=1.
  - While ex_ready=0, every ex_* output holds its value and RAddr1/RAddr2 stay stable.
- Load-use hazard:
  - Condition: ex_valid & ex_mem_rd & ex_waddr!=0, and ex_waddr equals a used source of the decoding instruction.
  - Response: ID/EX loads a bubble (ex_valid=0, ex_wen=0) and the instruction stays held.
  - Exactly one bubble per hazard; issue resumes the next cycle.
- FSM states:
  - RUN → STALL on hazard with ex_ready=1.
  - STALL → RUN unconditionally next cycle.
  - RUN with held_valid=0 → if_ready=1.
- flush (highest priority):
  - Same cycle: held_valid←0, ID/EX←bubble, FSM←RUN, incoming if_instr discarded.
  - Next cycle: if_ready=1.
- Simultaneous events:
  - flush beats hazard, and flush beats ex_ready=0.
  - Hazard and ex_ready=0 together: hold, no bubble, hazard re-evaluated next cycle.
- Reset (any cycle, including mid-stall): held_valid=0, state=RUN, ex_valid=0, ex_op=0, ex_waddr=0, ex_wen=0, ex_mem_rd=0, ex_mem_wr=0, ex_imm=0, ex_illegal=0, RAddr1=RAddr2=0. if_ready=1 the cycle after reset deasserts.

Optional Feature:
- Macro ID_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (16 bits), reset to 0.
  - Increments once per inserted hazard bubble; saturates at 16'hFFFF.
  - Not incremented by flush or ex_ready backpressure.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then ADD R3,R1,R2 (16'h0312) with ex_ready=1 → RAddr1=1, RAddr2=2 same cycle; next cycle ex_valid=1, ex_op=0, ex_waddr=3, ex_wen=1.
- LW R4,[R1+2] (16'h8412), then ADD R5,R4,R6 (16'h0546) → one cycle ex_valid=0 with if_ready=0, then ADD issues; stall_cnt=1 when ID_STALL_CNT_EN is defined.
- LW R0,[R1] followed by ADD R5,R0,R6 → no bubble (waddr 0 gives ex_wen=0 and no hazard).
- ex_ready=0 for 3 cycles while SW (16'h9712) is held → ex_* and RAddr1=1/RAddr2=7 stable; if_ready=0; SW issues on the first ex_ready=1.
- Hazard pending and flush=1 in the same cycle → next cycle ex_valid=0, if_ready=1, state RUN, no stall counted.
- op 16'hE000 → ex_illegal=1 for one cycle, ex_valid=0; Reset asserted mid-STALL → all outputs 0 on the next edge.
